inval_dispatcher: RTL and testbench

INVAL_DISPATCHER -- requirements
Module: inval_dispatcher

---
 rtl/coh_pkg.sv | 18 +
 rtl/inval_pick.sv | 23 ++
 rtl/inval_dispatcher.sv | 155 +++++++++++++++
 tb/tb_inval_dispatcher.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/coh_pkg.sv
// rtl/coh_pkg.sv - shared coherence types for the directory and invalidation dispatcher
// Purpose: core count default, core id type and the dispatcher FSM state encoding.
// Ports: none (package).
package coh_pkg;

  localparam int NUM_CORES_DEF = 4;
  localparam int CORE_ID_W     = $clog2(NUM_CORES_DEF);

  typedef logic [CORE_ID_W-1:0] core_id_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2,
    DONE     = 2'd3
  } inv_state_e;

endpackage

// File: rtl/inval_pick.sv
// rtl/inval_pick.sv - lowest-set-bit picker for the invalidation send mask
// Purpose: returns the index of the lowest set bit of mask and whether any bit is set.
// Ports: mask (N-bit in), idx (index of lowest set bit, 0 when mask is empty), any (|mask).
module inval_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     mask,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top so the lowest set bit is the last writer.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) idx = IDX_W'(i);
    end
  end

  assign any = |mask;

endmodule

// File: rtl/inval_dispatcher.sv
// rtl/inval_dispatcher.sv - fans a directory response out into per-core invalidations
// Purpose: accepts one directory response, sends one invalidation per sharer (excluding
//   the requester) lowest core first, collects acks, then reports completion.
// Ports: clk/rst (async active-high); req_* directory response in (valid/ready, addr,
//   sharers, src); inv_* invalidation out (valid/ready, addr, dst); ack_i per-core ack
//   pulses; done_* completion out (valid/ready, addr, src); timeout_o sticky ack timeout.
// Build option: define INVAL_TIMEOUT_EN to bound the ack wait by TIMEOUT_CYCLES.
module inval_dispatcher
  import coh_pkg::*;
#(
  parameter int NUM_CORES      = NUM_CORES_DEF,
  parameter int ADDR_W         = 64,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int ID_W          = $clog2(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [ADDR_W-1:0]    req_addr_i,
  input  logic [NUM_CORES-1:0] req_sharers_i,
  input  logic [ID_W-1:0]      req_src_i,
  output logic                 inv_valid_o,
  input  logic                 inv_ready_i,
  output logic [ADDR_W-1:0]    inv_addr_o,
  output logic [ID_W-1:0]      inv_dst_o,
  input  logic [NUM_CORES-1:0] ack_i,
  output logic                 done_valid_o,
  input  logic                 done_ready_i,
  output logic [ADDR_W-1:0]    done_addr_o,
  output logic [ID_W-1:0]      done_src_o,
  output logic                 timeout_o
);

  inv_state_e           state_q;
  logic [NUM_CORES-1:0] to_send_q;
  logic [NUM_CORES-1:0] pending_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [ID_W-1:0]      src_q;

  logic [NUM_CORES-1:0] src_bit;
  logic [NUM_CORES-1:0] dst_bit;
  logic [NUM_CORES-1:0] req_targets;
  logic [NUM_CORES-1:0] pending_ack;
  logic [NUM_CORES-1:0] to_send_left;
  logic [ID_W-1:0]      pick_idx;
  logic                 pick_any;
  logic                 accept;
  logic                 inv_hs;
  logic                 done_hs;
  logic                 wait_expired;

  inval_pick #(
    .N     (NUM_CORES),
    .IDX_W (ID_W)
  ) u_pick (
    .mask (to_send_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign src_bit      = NUM_CORES'(1) << req_src_i;
  assign dst_bit      = NUM_CORES'(1) << pick_idx;
  assign req_targets  = req_sharers_i & ~src_bit;

  // Gated by rst so nothing can be accepted while reset is held.
  assign req_ready_o  = (state_q == IDLE) && !rst;
  assign inv_valid_o  = (state_q == SEND) && pick_any;
  assign done_valid_o = (state_q == DONE);
  assign inv_addr_o   = addr_q;
  assign inv_dst_o    = pick_idx;
  assign done_addr_o  = addr_q;
  assign done_src_o   = src_q;

  assign accept  = req_valid_i && req_ready_o;
  assign inv_hs  = inv_valid_o && inv_ready_i;
  assign done_hs = done_valid_o && done_ready_i;

  // Pending after this cycle's acks; an ack in the same cycle as its send counts,
  // and acks for cores that are not pending fall out of the AND.
  assign pending_ack  = pending_q & ~ack_i;
  assign to_send_left = inv_hs ? (to_send_q & ~dst_bit) : to_send_q;

`ifdef INVAL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic             timeout_q;

  // The counter sits at zero outside WAIT_ACK, so it starts from zero on every entry;
  // expiring one count early lands DONE exactly TIMEOUT_CYCLES after entry.
  assign wait_expired = (state_q == WAIT_ACK) &&
                        (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) &&
                        (pending_ack != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (state_q == WAIT_ACK) wait_cnt_q <= wait_cnt_q + 1'b1;
      else                     wait_cnt_q <= '0;
      if (wait_expired) timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  // Timeout compiled out: WAIT_ACK waits for acks indefinitely.
  localparam logic TIMEOUT_ACTIVE = 1'b0 && (TIMEOUT_CYCLES > 0);

  assign wait_expired = TIMEOUT_ACTIVE;
  assign timeout_o    = TIMEOUT_ACTIVE;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      to_send_q <= '0;
      pending_q <= '0;
      addr_q    <= '0;
      src_q     <= '0;
    end else begin
      if (state_q != IDLE) pending_q <= pending_ack;
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q    <= req_addr_i;
            src_q     <= req_src_i;
            to_send_q <= req_targets;
            pending_q <= req_targets;
            state_q   <= (req_targets == '0) ? DONE : SEND;
          end
        end
        SEND: begin
          to_send_q <= to_send_left;
          if (to_send_left == '0) state_q <= (pending_ack == '0) ? DONE : WAIT_ACK;
        end
        WAIT_ACK: begin
          if (pending_ack == '0) begin
            state_q <= DONE;
          end else if (wait_expired) begin
            pending_q <= '0;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (done_hs) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inval_dispatcher.sv
// tb/tb_inval_dispatcher.sv - directed and randomized bench for inval_dispatcher
module tb_inval_dispatcher;
  import coh_pkg::*;

  localparam int NC = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [63:0]   req_addr_i;
  logic [NC-1:0] req_sharers_i;
  core_id_t      req_src_i;
  logic          inv_valid_o;
  logic          inv_ready_i;
  logic [63:0]   inv_addr_o;
  core_id_t      inv_dst_o;
  logic [NC-1:0] ack_i;
  logic          done_valid_o;
  logic          done_ready_i;
  logic [63:0]   done_addr_o;
  core_id_t      done_src_o;
  logic          timeout_o;

  int vectors     = 0;
  int miscompares = 0;
  bit exp_timeout;

  always #5 clk = ~clk;

  inval_dispatcher #(
    .NUM_CORES      (NC),
    .ADDR_W         (64),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_addr_i    (req_addr_i),
    .req_sharers_i (req_sharers_i),
    .req_src_i     (req_src_i),
    .inv_valid_o   (inv_valid_o),
    .inv_ready_i   (inv_ready_i),
    .inv_addr_o    (inv_addr_o),
    .inv_dst_o     (inv_dst_o),
    .ack_i         (ack_i),
    .done_valid_o  (done_valid_o),
    .done_ready_i  (done_ready_i),
    .done_addr_o   (done_addr_o),
    .done_src_o    (done_src_o),
    .timeout_o     (timeout_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model at transaction level: targets are the sharers minus the requester,
  // sent lowest first, one per ready cycle; completion appears the cycle after both the
  // last send and the last ack, or TO cycles after the ack wait begins if an ack is withheld.
  task automatic run_txn(input logic [63:0] addr, input logic [3:0] sharers, input core_id_t src,
                         input int ready_pct, input int ready_hold, input int dmin, input int dmax,
                         input bit stray, input int withhold, input int done_pct);
    int       targets[$];
    int       ack_at[NC];
    logic [3:0] tmask, pend, ack_v;
    int       cyc, amax, done_start, k;
    bit       exp_inv, exp_done, rdy, dr, done_taken, finished, timed_out;

    tmask = sharers & ~(4'b0001 << src);
    for (int i = 0; i < NC; i++) begin
      ack_at[i] = -1;
      if (tmask[i]) targets.push_back(i);
    end
    timed_out  = (withhold >= 0) && tmask[withhold];
    done_start = (targets.size() == 0) ? 1 : 1000000;
    amax = 0; cyc = 0; done_taken = 0; finished = 0;

    chk("idle_req_ready", 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1; req_addr_i = addr; req_sharers_i = sharers; req_src_i = src;
    inv_ready_i = 1'b0; ack_i = '0; done_ready_i = 1'b0;

    while (!finished && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      req_valid_i = 1'b0;
      if (done_taken) begin
        chk("post_req_ready", 64'(req_ready_o), 64'd1);
        chk("post_inv_valid", 64'(inv_valid_o), 64'd0);
        chk("post_done_valid", 64'(done_valid_o), 64'd0);
        finished = 1;
        inv_ready_i = 1'b0; ack_i = '0; done_ready_i = 1'b0;
      end else begin
        exp_inv  = targets.size() != 0;
        exp_done = cyc >= done_start;
        if (exp_done && timed_out) exp_timeout = 1'b1;
        chk("inv_valid", 64'(inv_valid_o), 64'(exp_inv));
        if (exp_inv) begin
          chk("inv_dst", 64'(inv_dst_o), 64'(targets[0]));
          chk("inv_addr", inv_addr_o, addr);
        end
        chk("done_valid", 64'(done_valid_o), 64'(exp_done));
        if (exp_done) begin
          chk("done_addr", done_addr_o, addr);
          chk("done_src", 64'(done_src_o), 64'(src));
        end
        chk("busy_req_ready", 64'(req_ready_o), 64'd0);
        chk("timeout", 64'(timeout_o), 64'(exp_timeout));

        rdy = (cyc > ready_hold) && ($urandom_range(99, 0) < ready_pct);
        if (exp_inv && rdy) begin
          k = targets.pop_front();
          if (k != withhold) begin
            ack_at[k] = cyc + int'($urandom_range(dmax, dmin));
            if (ack_at[k] > amax) amax = ack_at[k];
          end
          if (targets.size() == 0)
            done_start = timed_out ? cyc + 1 + TO : ((amax > cyc) ? amax : cyc) + 1;
        end
        ack_v = '0; pend = '0;
        for (int i = 0; i < NC; i++) begin
          if (ack_at[i] == cyc) ack_v[i] = 1'b1;
          if (tmask[i] && (ack_at[i] < 0 || ack_at[i] >= cyc)) pend[i] = 1'b1;
        end
        if (stray) ack_v = ack_v | ((4'($urandom) | (4'b0001 << src)) & ~pend);
        inv_ready_i = rdy;
        ack_i = ack_v;
        dr = $urandom_range(99, 0) < done_pct;
        done_ready_i = dr;
        if (exp_done && dr) done_taken = 1;
      end
    end
    if (!finished) chk("txn_budget", 64'd0, 64'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_sharers_i = '0; req_src_i = '0;
    inv_ready_i = 1'b0; ack_i = '0; done_ready_i = 1'b0;
    exp_timeout = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_inv_valid", 64'(inv_valid_o), 64'd0);
    chk("rst_done_valid", 64'(done_valid_o), 64'd0);
    chk("rst_timeout", 64'(timeout_o), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_req_ready", 64'(req_ready_o), 64'd1);

    // sharers 1011 from core 0, acks two cycles after each send
    run_txn(64'h0000_1234_5678_9ab0, 4'b1011, 2'd0, 100, 0, 2, 2, 1'b0, -1, 100);
    // requester is the only sharer: straight to done, held a while
    run_txn(64'hdead_beef_0000_0040, 4'b0001, 2'd0, 100, 0, 0, 0, 1'b0, -1, 30);
    // inv_ready held low for five cycles
    run_txn(64'h0bad_cafe_0000_0080, 4'b0110, 2'd0, 100, 5, 1, 1, 1'b0, -1, 100);
    // acks during SEND plus stray acks to non-pending cores
    run_txn(64'h1111_2222_3333_40c0, 4'b1110, 2'd0, 100, 0, 0, 1, 1'b1, -1, 100);
`ifdef INVAL_TIMEOUT_EN
    // core 2 never acks
    run_txn(64'h7777_0000_0000_0100, 4'b0110, 2'd0, 100, 0, 1, 1, 1'b0, 2, 100);
`endif

    // reset while waiting for an ack
    req_valid_i = 1'b1; req_addr_i = 64'h5555_aaaa_0000_0140;
    req_sharers_i = 4'b0010; req_src_i = 2'd0;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    chk("rw_inv_valid", 64'(inv_valid_o), 64'd1);
    inv_ready_i = 1'b1;
    @(posedge clk); #1;
    inv_ready_i = 1'b0;
    chk("rw_wait_inv", 64'(inv_valid_o), 64'd0);
    chk("rw_wait_done", 64'(done_valid_o), 64'd0);
    chk("rw_wait_ready", 64'(req_ready_o), 64'd0);
    chk("rw_sticky_timeout", 64'(timeout_o), 64'(exp_timeout));
    #2 rst = 1'b1;
    #1;
    chk("rw_rst_inv", 64'(inv_valid_o), 64'd0);
    chk("rw_rst_done", 64'(done_valid_o), 64'd0);
    chk("rw_rst_timeout", 64'(timeout_o), 64'd0);
    exp_timeout = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rw_after_ready", 64'(req_ready_o), 64'd1);
    chk("rw_after_inv", 64'(inv_valid_o), 64'd0);
    chk("rw_after_done", 64'(done_valid_o), 64'd0);
    run_txn(64'h0123_4567_89ab_cd00, 4'b0100, 2'd1, 100, 0, 0, 0, 1'b0, -1, 100);

    for (int n = 0; n < 40; n++)
      run_txn({$urandom, $urandom}, 4'($urandom), 2'($urandom), 70, 0, 0, 3, 1'($urandom), -1, 60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
